// File: rtl/fmt_ini_chk_pkg.sv
// Shared types and error-bit indices for the formatter-initiator protocol checker.
package fmt_ini_chk_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int ACK_NO_VAL = 0;
  localparam int VAL_DROP   = 1;
  localparam int UNSTABLE   = 2;
  localparam int TIMEOUT    = 3;
  localparam int ID_RANGE   = 4;
  localparam int ERR_NUM    = 5;

endpackage

// File: rtl/fmt_ini_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module fmt_ini_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/fmt_ini_prot_chk.sv
// Passive valid/ack handshake checker with per-id transfer and error statistics.
// Define FMT_INI_PROT_CHK_MSG_EN to get an $error message for every raised error bit.
module fmt_ini_prot_chk
  import fmt_ini_chk_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ID_W        = 2,
  parameter int NUM_SLV     = 3,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_chk_prot,
  input  logic                     a2f_val,
  input  logic [ID_W-1:0]          a2f_id,
  input  logic [DATA_W-1:0]        a2f_dat,
  input  logic                     f2a_ack,
  output logic [ERR_NUM-1:0]       err_pulse,
  output logic                     err_sticky,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [NUM_SLV*CNT_W-1:0] xfer_cnt,
  output logic                     busy
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(ACK_TIMEOUT);

  state_t              state, state_n;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   dat_q;
  logic [ERR_NUM-1:0]  err_n;
  logic                cap, to_clr, to_inc, xfer;
  logic [TO_W-1:0]     tcnt;
  logic [31:0]         id_ext;

  assign id_ext = 32'(a2f_id);
  assign busy   = (state == WAIT);

  always_comb begin
    state_n = state;
    err_n   = '0;
    cap     = 1'b0;
    to_clr  = 1'b0;
    to_inc  = 1'b0;
    xfer    = 1'b0;
    if (!en_chk_prot) begin
      state_n = IDLE;
    end else begin
      xfer = a2f_val && f2a_ack;
      if (f2a_ack && !a2f_val) err_n[ACK_NO_VAL] = 1'b1;
      if (a2f_val && (id_ext >= 32'(NUM_SLV))) err_n[ID_RANGE] = 1'b1;
      unique case (state)
        IDLE: begin
          if (a2f_val && !f2a_ack) begin
            cap     = 1'b1;
            to_clr  = 1'b1;
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (!a2f_val) begin
            err_n[VAL_DROP] = 1'b1;
            state_n         = IDLE;
          end else begin
            if ((a2f_id != id_q) || (a2f_dat != dat_q)) begin
              err_n[UNSTABLE] = 1'b1;
              cap             = 1'b1;
            end
            if (f2a_ack) begin
              state_n = IDLE;
            end else begin
              // Counter stops at ACK_TIMEOUT so the timeout fires once per episode
              to_inc = (tcnt != TO_MAX);
              if (tcnt == TO_LAST) err_n[TIMEOUT] = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      err_pulse  <= '0;
      err_sticky <= 1'b0;
      id_q       <= '0;
      dat_q      <= '0;
    end else begin
      state     <= state_n;
      err_pulse <= err_n;
      if (|err_n) err_sticky <= 1'b1;
      if (cap) begin
        id_q  <= a2f_id;
        dat_q <= a2f_dat;
      end
    end
  end

  fmt_ini_sat_cnt #(.W(TO_W)) u_to_cnt (
    .clk (clk),
    .rst (rst),
    .clr (to_clr),
    .inc (to_inc),
    .q   (tcnt)
  );

  fmt_ini_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (|err_n),
    .q   (err_cnt)
  );

  for (genvar k = 0; k < NUM_SLV; k++) begin : g_xfer
    fmt_ini_sat_cnt #(.W(CNT_W)) u_xfer_cnt (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .inc (xfer && (id_ext == 32'(k))),
      .q   (xfer_cnt[k*CNT_W +: CNT_W])
    );
  end

`ifdef FMT_INI_PROT_CHK_MSG_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (err_n[ACK_NO_VAL]) $error("fmt_ini_prot_chk::[protocol error] ACK_NO_VAL id=%0d", a2f_id);
      if (err_n[VAL_DROP])   $error("fmt_ini_prot_chk::[protocol error] VAL_DROP id=%0d", a2f_id);
      if (err_n[UNSTABLE])   $error("fmt_ini_prot_chk::[protocol error] UNSTABLE id=%0d", a2f_id);
      if (err_n[TIMEOUT])    $error("fmt_ini_prot_chk::[protocol error] TIMEOUT id=%0d", a2f_id);
      if (err_n[ID_RANGE])   $error("fmt_ini_prot_chk::[protocol error] ID_RANGE id=%0d", a2f_id);
    end
  end
`else
`endif

endmodule

// File: doc/fmt_ini_prot_chk.md
Name: fmt_ini_prot_chk

Overview:
Synthesisable, parametrised protocol checker for the formatter-initiator valid/ack channel (a2f_val/a2f_id/a2f_dat vs f2a_ack). It generalises the single ack-without-valid check to a full handshake checker covering valid drop, payload stability, ack timeout and id range. It also keeps saturating per-id transfer counters and an error counter. It sits passively beside the arbiter-to-formatter link in RTL and in the bench.

Parameters:
DATA_W, 32, payload width of a2f_dat
ID_W, 2, width of a2f_id
NUM_SLV, 3, number of legal ids (0..NUM_SLV-1); must be <= 2**ID_W
ACK_TIMEOUT, 16, cycles in WAIT before the timeout error fires; must be >= 1
CNT_W, 16, width of every statistics counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en_chk_prot  in  1  checker enable
a2f_val  in  1  request valid
a2f_id  in  ID_W  request id
a2f_dat  in  DATA_W  request payload
f2a_ack  in  1  formatter ack
err_pulse  out  5  one-cycle error flags; bit indices come from the package
err_sticky  out  1  OR of all errors since reset
err_cnt  out  CNT_W  count of cycles with any error, saturating
xfer_cnt  out  NUM_SLV*CNT_W  per-id completed transfers, saturating; id k occupies bits [k*CNT_W +: CNT_W]
busy  out  1  FSM in WAIT

Behaviour:
- Reset: one clock, synchronous active-high, rst=1 sampled at posedge. All outputs and counters go to 0 and the FSM goes to IDLE. rst has priority over every other input.
- Sampling: inputs are sampled at posedge clk. Error pulses, counters and busy update at that edge, so an error is visible one cycle after the violating sample (latency 1).
- Transfer: occurs on a sampled cycle with val=1 and ack=1.
- FSM states: IDLE and WAIT.
- IDLE, val=1 and ack=0: capture id and dat, clear the timeout counter, go to WAIT.
- IDLE, val=1 and ack=1: zero-wait transfer, stay in IDLE.
- WAIT, val=0: raise VAL_DROP, go to IDLE.
- WAIT, val=1 and id/dat differ from the captured values: raise UNSTABLE, recapture, stay in WAIT. The timeout counter is not cleared.
- WAIT, val=1 and ack=1: transfer, go to IDLE. The stability check still applies on the ack cycle.
- Any state, ack=1 and val=0: raise ACK_NO_VAL.
- Any sample with val=1 and id >= NUM_SLV: raise ID_RANGE every such cycle. No xfer_cnt update for an out-of-range id.
- Timeout: the counter increments each cycle in WAIT without ack. When it reaches ACK_TIMEOUT, raise TIMEOUT exactly once per WAIT episode. The counter then saturates and the FSM stays in WAIT.
- Simultaneous errors: all applicable err_pulse bits assert together. err_cnt increments by exactly 1 for that cycle.
- Saturation: err_cnt and every xfer_cnt slice hold at all-ones.
- en_chk_prot=0: err_pulse forced to 0, FSM forced to IDLE, counters and err_sticky hold. The first enabled sample is treated as from IDLE.

Optional Feature:
- Macro: FMT_INI_PROT_CHK_MSG_EN.
- Defined: every err_pulse bit also issues $error("fmt_ini_prot_chk::[protocol error] <name> id=%0d") in the same cycle, where <name> is the error name.
- Undefined: no messages are produced; the block is purely synthesisable and its cycle behaviour is identical.

Decomposition:
- Package fmt_ini_chk_pkg holds:
  - state enum {IDLE, WAIT};
  - error-bit localparams ACK_NO_VAL=0, VAL_DROP=1, UNSTABLE=2, TIMEOUT=3, ID_RANGE=4;
  - ERR_NUM=5.
- Sub-module fmt_ini_sat_cnt (parametrised width, inc, clr, saturating) is used for err_cnt, the timeout counter and each xfer_cnt slice.

Test Plan:
- val=1 id=1 dat=32'hA5A5_0001 held 3 cycles, ack on cycle 3 -> err_pulse=0, busy=1 for 2 cycles, xfer_cnt[id1]=1.
- ack=1 while val=0 for 1 cycle -> err_pulse[0]=1 for one cycle, err_cnt=1, err_sticky=1.
- val=1 ack=0 id=0, then dat changes to 32'h1 the next cycle -> UNSTABLE pulse; val drops the following cycle -> VAL_DROP pulse; err_cnt=2.
- ACK_TIMEOUT=4, val=1 with no ack for 10 cycles -> single TIMEOUT pulse 4 cycles after entering WAIT; a later ack gives xfer_cnt=1.
- val=1 ack=1 id=3 with NUM_SLV=3 -> ID_RANGE pulse, all xfer_cnt unchanged; the same cycle with ack=1 and val=0 on another cycle gives a separate count.
- CNT_W=2, 5 transfers on id 2 -> xfer_cnt[id2]=3. en_chk_prot=0 with an ack-no-val violation -> err_pulse=0, err_cnt unchanged. rst mid-WAIT -> busy=0 and all counters 0 the next cycle.
